// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side controllers: FSM states, default
// address base and half-word select encodings.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

  // LSB of the SRAM half-word address: low half carries data bits 15:0.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Phase counter: counts enabled cycles from zero, flags the TERM-th cycle.
// Synchronous clear has priority over enable; tc is combinational from count.
module wait_counter #(
  parameter int unsigned TERM = 5,
  parameter int unsigned W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage word access serviced as two half-word phases on a 16-bit async SRAM.
// WAIT_CYCLES=1 gives no we_n-low cycle, so values below 2 are only usable for reads.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned IW = SRAM_AW - 1;

  state_t        state, state_nxt;
  logic          req;
  logic          tc;
  logic [IW-1:0] req_idx;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          is_wr_q;
  logic [15:0]   lo_hold;

  assign req     = wr_en | rd_en;
  // Unsigned wrap makes addresses below the base alias to the top of the SRAM.
  assign req_idx = IW'((address - ADDR_BASE) >> 2);

  wait_counter #(
    .TERM (WAIT_CYCLES),
    .W    (4)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr ((state == IDLE) || (state == DONE) || tc),
    .en  ((state == LOW) || (state == HIGH)),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (tc)  state_nxt = HIGH;
      HIGH:    if (tc)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      lo_hold   <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        idx_q   <= req_idx;
        wdata_q <= write_data;
        is_wr_q <= wr_en;
      end
      if (state == LOW && tc && !is_wr_q) lo_hold <= sram_dq_i;
      if (state == HIGH && tc && !is_wr_q) read_data <= {sram_dq_i, lo_hold};
    end
  end

  // we_n rises on the last cycle of a write phase while address/data stay put.
  always_comb begin
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    ready      = 1'b0;
    case (state)
      IDLE: ready = ~req;
      LOW: begin
        sram_addr = {idx_q, HALF_LO};
        if (is_wr_q) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = wdata_q[15:0];
          sram_we_n  = tc;
        end
      end
      HIGH: begin
        sram_addr = {idx_q, HALF_HI};
        if (is_wr_q) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = wdata_q[31:16];
          sram_we_n  = tc;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side responder for the pipeline's MEM stage. Accepts one word read or write request at a time and services it against an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states.
- Drives `ready` low while an access is outstanding so the pipeline freezes. Returns the assembled 32-bit read word when `ready` rises.
- Sits between the MEM stage and the board SRAM pins. Replaces the in-stage register-array memory.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 5: cycles each half-word phase is held on the SRAM pins (legal range 1..15).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request from MEM stage (MEM_W_EN).
- rd_en  in  1  read request from MEM stage (MEM_R_EN).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Value_Rm).
- read_data  out  32  loaded word, valid when ready=1 after a read.
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_o  out  16  write data to SRAM.
- sram_dq_i  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives DQ bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Clock and reset: clk is the clock; rst is a synchronous, active-high reset.
- Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1. Reset mid-access aborts it immediately at that edge; no partial-write completion.
- Address translation:
  - word index = (address - ADDR_BASE) >> 2, 32-bit unsigned wrap.
  - Truncate to SRAM_AW-1 bits.
  - Low half at {idx,0} (data bits 15:0); high half at {idx,1} (bits 31:16).
  - Addresses below ADDR_BASE wrap with no error.
- Request qualification: req = wr_en | rd_en. If both are set, the access is a write (rd_en ignored).
- State machine IDLE -> LOW -> HIGH -> DONE -> IDLE:
  - IDLE: if req, latch address index, write_data and the op type; clear counter; go to LOW. Otherwise stay.
  - LOW: sram_addr={idx,0}. For a write: sram_dq_oe=1, sram_dq_o=wdata[15:0], sram_we_n=0 on all cycles except the last.
    - Counter increments each cycle. At counter==WAIT_CYCLES-1: a read captures sram_dq_i into low-half hold register; clear counter; go to HIGH.
  - HIGH: same as LOW with {idx,1} and wdata[31:16]. Read capture goes into read_data[31:16], and the low-half hold register is committed to read_data[15:0] at the same edge. Then go to DONE.
  - DONE: one cycle, pins idle (oe=0, we_n=1). Go to IDLE unconditionally.
- sram_we_n rules:
  - Deasserted (1) in the final cycle of each write phase, so address and data stay stable across the rising we_n edge.
  - With WAIT_CYCLES=1 the phase has no we_n-low cycle. WAIT_CYCLES<2 is therefore legal only for reads. This is documented as a constraint.
- ready (combinational): ready = (state==IDLE & ~req) | (state==DONE).
  - Latency for the first presentation of a request at cycle 0: ready=0 on cycles 0..2*WAIT_CYCLES, ready=1 on cycle 2*WAIT_CYCLES+1.
  - Default WAIT_CYCLES=5: ready=1 on cycle 11.
- Back-to-back requests: the pipeline advances at the DONE edge. A new req seen in IDLE on the next cycle starts a fresh access, with ready low again on that same cycle. There is no dead cycle beyond DONE.
- Request stability: inputs may change after the IDLE->LOW edge without effect, because all values are latched. read_data holds its value until the next read completes; writes never modify it.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, LOW, HIGH, DONE}.
  - ADDR_BASE default constant.
  - Half-word select constants.
- One natural sub-module: wait_counter, a parameterised phase counter with clear and a terminal-count output. It is reused by the future instruction-side controller. The FSM and datapath stay in sram_ctrl.

Test Plan:
- Write/readback:
  - Stimulus: wr_en=1, address=1024, write_data=0xDEADBEEF.
  - Response: sram_addr 0 then 1; dq_o 0xBEEF then 0xDEAD; we_n low 4 cycles per phase; ready=1 at cycle 11.
  - Then rd_en=1 at the same address with an SRAM model: read_data=0xDEADBEEF at cycle 11.
- Address mapping: read address=1036 -> sram_addr 6 then 7. Address=1020 -> wraps to index 0x1FFFF (SRAM_AW=18), giving sram_addr 0x3FFFE then 0x3FFFF.
- Idle and priority: req=0 -> ready=1, we_n=1, oe=0 constant. rd_en=wr_en=1 -> write phases occur and read_data is unchanged.
- Back-to-back: two reads (addr 1024, then 1028) held until each ready. Each shows ready low for 11 cycles; second read_data is the word at SRAM index 1.
- Reset mid-access: assert rst during HIGH of a write. Next cycle: state IDLE, we_n=1, oe=0, read_data=0, ready follows req. The subsequent write completes normally.
- Parameter sweep: WAIT_CYCLES=2 -> read ready at cycle 5; WAIT_CYCLES=15 -> ready at cycle 31.
